// File: rtl/ifns_pkg.sv
// ---------------------------------------------------------------------------
// ifns_pkg
// Shared constants for the 14-bit / 20-wire IFNS crosstalk-avoidance code.
// The weight vector here is the single source used by the encoder, the
// decoder and the decoder reference model, so all of them agree by
// construction.
// ---------------------------------------------------------------------------
package ifns_pkg;

    // Codeword width (wires) and data width (bits)
    localparam int unsigned IFNS_N     = 20;
    localparam int unsigned IFNS_K     = 14;

    // Largest data value representable in IFNS_K bits
    localparam int unsigned IFNS_MAX   = 16383;

    // Width of every weighted sum; the all-ones codeword sums to 28655
    localparam int unsigned IFNS_SUM_W = 15;

    // Codeword bits handled by one partial-sum group
    localparam int unsigned IFNS_GRP_W = 5;

    // Number of partial-sum groups covering the codeword
    localparam int unsigned IFNS_NGRP  = IFNS_N / IFNS_GRP_W;

    typedef logic [IFNS_SUM_W-1:0] ifns_sum_t;

    // Registered decode result
    typedef struct packed {
        logic              err;
        logic [IFNS_K-1:0] data;
    } ifns_result_t;

    // Fibonacci weights, indexed by codeword bit position 1..20
    localparam logic [IFNS_SUM_W-1:0] IFNS_W [1:IFNS_N] = '{
        15'd1,    15'd2,    15'd3,    15'd5,    15'd8,
        15'd13,   15'd21,   15'd34,   15'd55,   15'd89,
        15'd144,  15'd233,  15'd377,  15'd610,  15'd987,
        15'd1597, 15'd2584, 15'd4181, 15'd6765, 15'd10946
    };

endpackage : ifns_pkg

// File: rtl/ifns_decoder_20_if.sv
// ---------------------------------------------------------------------------
// ifns_decoder_20_if
// Bus between an IFNS link receiver front-end and the decoder.
//   valid_in    : codein carries a new codeword this cycle
//   codein      : 20-wire codeword, bit i carries weight IFNS_W[i]
//   err_cnt_clr : synchronous clear of the decode-error counter
//   valid_out   : dataout / err_out are valid this cycle
//   dataout     : decoded 14-bit data word (0 when flagged)
//   err_out     : codeword sum exceeded the 14-bit range
//   err_cnt     : saturating count of flagged codewords
// Modports: master = the side driving codewords, slave = the decoder.
// ---------------------------------------------------------------------------
interface ifns_decoder_20_if #(
    parameter int unsigned ERR_CNT_W = 16
) ();
    import ifns_pkg::*;

    logic                 valid_in;
    logic [IFNS_N:1]      codein;
    logic                 err_cnt_clr;
    logic                 valid_out;
    logic [IFNS_K-1:0]    dataout;
    logic                 err_out;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output valid_in,
        output codein,
        output err_cnt_clr,
        input  valid_out,
        input  dataout,
        input  err_out,
        input  err_cnt
    );

    modport slave (
        input  valid_in,
        input  codein,
        input  err_cnt_clr,
        output valid_out,
        output dataout,
        output err_out,
        output err_cnt
    );

endinterface : ifns_decoder_20_if

// File: rtl/ifns_group_sum.sv
// ---------------------------------------------------------------------------
// ifns_group_sum
// Combinational Fibonacci-weighted sum of one 5-bit codeword slice.
//   BASE  : codeword bit index of slice[0] (1, 6, 11 or 16)
//   slice : codeword bits [BASE+4:BASE]
//   sum_c : weighted sum of the set bits, 15 bits
// ---------------------------------------------------------------------------
module ifns_group_sum
    import ifns_pkg::*;
#(
    parameter int unsigned BASE = 1
) (
    input  logic [IFNS_GRP_W-1:0] slice,
    output ifns_sum_t             sum_c
);

    // Add the weight of each set bit; the largest group (bits 20..16)
    // sums to 26073, so 15 bits never overflow
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < IFNS_GRP_W; i++) begin
            if (slice[i]) begin
                sum_c = sum_c + IFNS_W[BASE + i];
            end
        end
    end

endmodule : ifns_group_sum

// File: rtl/ifns_decoder_20.sv
// ---------------------------------------------------------------------------
// ifns_decoder_20
// Receive-side IFNS 14b/20-wire decoder. Three register stages:
//   stage 0 : capture codeword and valid
//   stage 1 : four 5-bit group partial sums
//   stage 2 : final sum, range check, result and valid
// A codeword presented before edge k is reflected at the outputs after
// edge k+2, one word per cycle, no backpressure.
// Ports:
//   clock : rising-edge clock
//   rst   : asynchronous active-high reset
//   bus   : ifns_decoder_20_if.slave (codeword in, decoded word and
//           error diagnostics out)
// ---------------------------------------------------------------------------
module ifns_decoder_20
    import ifns_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input logic              clock,
    input logic              rst,
    ifns_decoder_20_if.slave bus
);

    // Stage 0 registers
    logic [IFNS_N:1] code_r;
    logic            v0;

    // Stage 1 registers
    ifns_sum_t       part_c [IFNS_NGRP];
    ifns_sum_t       part_r [IFNS_NGRP];
    logic            v1;

    // Stage 2 combinational result and registers
    ifns_sum_t       sum_c;
    ifns_result_t    res_c;
    ifns_result_t    res_r;
    logic            valid_r;

    // Error counter
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Stage 0: capture every cycle; data may load during bubbles
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            code_r <= '0;
            v0     <= 1'b0;
        end else begin
            code_r <= bus.codein;
            v0     <= bus.valid_in;
        end
    end

    // Partial sums over bits [5:1], [10:6], [15:11], [20:16]
    for (genvar g = 0; g < IFNS_NGRP; g++) begin : g_grp
        ifns_group_sum #(
            .BASE (g * IFNS_GRP_W + 1)
        ) u_grp (
            .slice (code_r[g*IFNS_GRP_W+IFNS_GRP_W -: IFNS_GRP_W]),
            .sum_c (part_c[g])
        );
    end

    // Stage 1: register partial sums
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IFNS_NGRP; i++) begin
                part_r[i] <= '0;
            end
            v1 <= 1'b0;
        end else begin
            for (int i = 0; i < IFNS_NGRP; i++) begin
                part_r[i] <= part_c[i];
            end
            v1 <= v0;
        end
    end

    // Final sum and range check; out-of-range words decode to zero
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < IFNS_NGRP; i++) begin
            sum_c = sum_c + part_r[i];
        end
        res_c.err  = (sum_c > ifns_sum_t'(IFNS_MAX));
        res_c.data = res_c.err ? '0 : sum_c[IFNS_K-1:0];
    end

    // Stage 2: output registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            res_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            res_r   <= res_c;
            valid_r <= v1;
        end
    end

    // Count flagged output cycles; clear wins, saturate at all-ones
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (bus.err_cnt_clr) begin
            err_cnt_r <= '0;
        end else if (valid_r && res_r.err && (err_cnt_r != '1)) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
        end
    end

    assign bus.valid_out = valid_r;
    assign bus.dataout   = res_r.data;
    assign bus.err_out   = res_r.err;
    assign bus.err_cnt   = err_cnt_r;

endmodule : ifns_decoder_20

// File: tb/tb_ifns_decoder_20.sv
// ---------------------------------------------------------------------------
// tb_ifns_decoder_20
// Directed, self-checking bench. Each driven slot pushes its expected
// result into a scoreboard queue; the entry is popped when that slot
// reaches the outputs (after the third rising edge). err_cnt is tracked
// by a cycle model. The counter is narrowed to 4 bits so saturation is
// reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_ifns_decoder_20;
    import ifns_pkg::*;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic              v;
        logic              e;
        logic [IFNS_K-1:0] d;
    } exp_t;

    logic clock;
    logic rst;

    ifns_decoder_20_if #(.ERR_CNT_W(CW)) bus ();

    ifns_decoder_20 #(.ERR_CNT_W(CW)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t          exp_q [$];
    logic [CW-1:0] exp_cnt;
    logic          prev_ve;
    int            passed;
    int            total;

    // Reference decode straight from the weight table
    function automatic int unsigned model_sum(input logic [IFNS_N:1] c);
        int unsigned s;
        s = 0;
        for (int i = 1; i <= IFNS_N; i++) begin
            if (c[i]) s += IFNS_W[i];
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one slot, clock it, then check the slot leaving the pipeline
    task automatic step(input logic vin, input logic [IFNS_N:1] code, input logic clr);
        exp_t        x;
        exp_t        cur;
        int unsigned s;
        bus.valid_in    = vin;
        bus.codein      = code;
        bus.err_cnt_clr = clr;
        s   = model_sum(code);
        x.v = vin;
        x.e = (s > IFNS_MAX);
        x.d = x.e ? '0 : s[IFNS_K-1:0];
        exp_q.push_back(x);
        @(posedge clock);
        #1;
        if (clr)                        exp_cnt = '0;
        else if (prev_ve && exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
        cur = '0;
        if (exp_q.size() >= 3) cur = exp_q.pop_front();
        chk("valid_out", 32'(bus.valid_out), 32'(cur.v));
        if (cur.v) begin
            chk("dataout", 32'(bus.dataout), 32'(cur.d));
            chk("err_out", 32'(bus.err_out), 32'(cur.e));
        end
        chk("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
        prev_ve = cur.v && cur.e;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
        chk({tag, "_data"},  32'(bus.dataout),   32'd0);
        chk({tag, "_err"},   32'(bus.err_out),   32'd0);
        chk({tag, "_cnt"},   32'(bus.err_cnt),   32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cnt = '0;
        prev_ve = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        model_reset();
        bus.valid_in    = 1'b0;
        bus.codein      = '0;
        bus.err_cnt_clr = 1'b0;

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
            chk_idle("reset");
        end
        rst = 1'b0;

        // Single word of weight 1
        step(1'b1, 20'h00001, 1'b0);
        repeat (3) step(1'b0, 20'h0, 1'b0);

        // Back-to-back: 10947, 16347, 0
        step(1'b1, 20'h80001, 1'b0);
        step(1'b1, 20'hA4800, 1'b0);
        step(1'b1, 20'h00000, 1'b0);
        repeat (3) step(1'b0, 20'h0, 1'b0);

        // Out of range: 16724 and the all-ones word
        step(1'b1, 20'hA8000, 1'b0);
        step(1'b1, 20'hFFFFF, 1'b0);
        repeat (4) step(1'b0, 20'h0, 1'b0);

        // Bubble with an all-ones word that must not count
        step(1'b1, 20'h00010, 1'b0);
        step(1'b0, 20'hFFFFF, 1'b0);
        step(1'b1, 20'h00100, 1'b0);
        repeat (4) step(1'b0, 20'h0, 1'b0);

        // Drive the counter into saturation
        repeat ((1 << CW) + 3) step(1'b1, 20'hFFFFF, 1'b0);
        repeat (4) step(1'b0, 20'h0, 1'b0);

        // Clear while an error is on the outputs, with errors continuing
        repeat (4) step(1'b1, 20'hFFFFF, 1'b0);
        step(1'b1, 20'hFFFFF, 1'b1);
        repeat (2) step(1'b1, 20'hFFFFF, 1'b0);
        repeat (3) step(1'b0, 20'h0, 1'b0);

        // Async reset between edges with the pipeline full
        step(1'b1, 20'hFFFFF, 1'b0);
        step(1'b1, 20'h00003, 1'b0);
        step(1'b1, 20'hA8000, 1'b0);
        step(1'b1, 20'h00040, 1'b0);
        bus.valid_in = 1'b0;
        bus.codein   = '0;
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        model_reset();
        @(posedge clock);
        #1;
        chk_idle("rst_hold");
        rst = 1'b0;

        // Flushed words must not surface; a new word lands on time
        repeat (4) step(1'b0, 20'h0, 1'b0);
        step(1'b1, 20'h00020, 1'b0);
        repeat (3) step(1'b0, 20'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_ifns_decoder_20
